// File: rtl/shift_reg_loader_pkg.sv
// rtl/shift_reg_loader_pkg.sv - shared state encoding and derived-width helpers
// for the shift register loader.
package shift_reg_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } state_t;

   function automatic int calc_w_depth(input int r_depth, input int r_dw, input int w_dw);
      return (r_depth * r_dw) / w_dw;
   endfunction

   // A depth of one still needs a one-bit index.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_loader_wrap_counter.sv
// rtl/shift_reg_loader_wrap_counter.sv - stallable up-counter that wraps to zero
// after reaching a runtime maximum.
module wrap_counter
   import shift_reg_loader_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clken,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (clken) begin
         if (clr) begin
            r_count <= '0;
         end else if (inc) begin
            r_count <= (r_count == max) ? '0 : r_count + WIDTH'(1);
         end
      end
   end

   assign count  = r_count;
   assign at_max = (r_count == max);

endmodule

// File: rtl/shift_reg_loader.sv
// rtl/shift_reg_loader.sv - loads a tile of wide words into the cyclic shift
// register, then rotates it for a configured number of passes.
module shift_reg_loader
   import shift_reg_loader_pkg::*;
#(
   parameter int R_DEPTH      = 24,
   parameter int R_DATA_WIDTH = 16,
   parameter int W_DATA_WIDTH = 192,
   parameter int PASS_WIDTH   = 16,
   localparam int W_DEPTH      = calc_w_depth(R_DEPTH, R_DATA_WIDTH, W_DATA_WIDTH),
   localparam int W_ADDR_WIDTH = addr_width(W_DEPTH),
   localparam int R_ADDR_WIDTH = addr_width(R_DEPTH)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    clken,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [W_ADDR_WIDTH-1:0] cfg_w_addr_max,
   input  logic [R_ADDR_WIDTH-1:0] cfg_r_addr_max,
   input  logic [PASS_WIDTH-1:0]   cfg_passes,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [W_DATA_WIDTH-1:0] s_data,
   input  logic                    s_last,
   output logic                    w_en,
   output logic                    r_en,
   output logic [W_DATA_WIDTH-1:0] w_data,
   output logic [W_ADDR_WIDTH-1:0] w_addr_max,
   output logic [R_ADDR_WIDTH-1:0] r_addr_max,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic                    done,
   output logic                    err_last
);

   state_t                  r_state, w_state_nxt;
   logic [W_ADDR_WIDTH-1:0] r_w_max;
   logic [R_ADDR_WIDTH-1:0] r_r_max;
   logic [PASS_WIDTH-1:0]   r_passes;
   logic                    r_done, r_err_last;
   logic                    w_done_nxt, w_cfg_fire;
   logic [W_ADDR_WIDTH-1:0] w_w_cnt;
   logic [R_ADDR_WIDTH-1:0] w_r_cnt;
   logic [PASS_WIDTH-1:0]   w_unused_pass_cnt;
   logic                    w_w_at_max, w_r_at_max, w_pass_at_max;

   assign cfg_ready  = (r_state == IDLE);
   assign s_ready    = (r_state == LOAD) && clken;
   assign w_en       = s_valid && s_ready;
   assign w_data     = s_data;
   assign m_valid    = (r_state == STREAM) && clken;
   assign r_en       = m_valid && m_ready;
   assign m_last     = m_valid && (w_r_cnt == r_r_max);
   assign w_cfg_fire = cfg_valid && cfg_ready && clken;
   assign w_addr_max = r_w_max;
   assign r_addr_max = r_r_max;
   assign done       = r_done;
   assign err_last   = r_err_last;

   wrap_counter #(.WIDTH(W_ADDR_WIDTH)) u_w_cnt (
      .clk(clk), .resetn(resetn), .clken(clken), .clr(w_cfg_fire), .inc(w_en),
      .max(r_w_max), .count(w_w_cnt), .at_max(w_w_at_max)
   );

   wrap_counter #(.WIDTH(R_ADDR_WIDTH)) u_r_cnt (
      .clk(clk), .resetn(resetn), .clken(clken), .clr(w_cfg_fire), .inc(r_en),
      .max(r_r_max), .count(w_r_cnt), .at_max(w_r_at_max)
   );

   // Only consulted in STREAM, where passes is at least one.
   wrap_counter #(.WIDTH(PASS_WIDTH)) u_pass_cnt (
      .clk(clk), .resetn(resetn), .clken(clken), .clr(w_cfg_fire),
      .inc(r_en && w_r_at_max), .max(r_passes - PASS_WIDTH'(1)),
      .count(w_unused_pass_cnt), .at_max(w_pass_at_max)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else if (clken) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cfg_fire) w_state_nxt = LOAD;
         end
         LOAD: begin
            if (w_en && w_w_at_max) begin
               if (r_passes == '0) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = STREAM;
               end
            end
         end
         STREAM: begin
            if (r_en && w_r_at_max && w_pass_at_max) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // s_last is advisory: a mismatch is flagged but never alters the load length.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_w_max    <= '0;
         r_r_max    <= '0;
         r_passes   <= '0;
         r_done     <= 1'b0;
         r_err_last <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         if (w_cfg_fire) begin
            r_w_max    <= cfg_w_addr_max;
            r_r_max    <= cfg_r_addr_max;
            r_passes   <= cfg_passes;
            r_err_last <= 1'b0;
         end else if (w_en && (s_last != (w_w_cnt == r_w_max))) begin
            r_err_last <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shift_reg_loader.sv
// tb/tb_shift_reg_loader.sv - scoreboard bench for shift_reg_loader.
module tb_shift_reg_loader;

   localparam int W_AW = 1;
   localparam int R_AW = 5;
   localparam int PW   = 16;
   localparam int WDW  = 192;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            clken = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [W_AW-1:0] cfg_w_addr_max = '0;
   logic [R_AW-1:0] cfg_r_addr_max = '0;
   logic [PW-1:0]   cfg_passes = '0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [WDW-1:0]  s_data = '0;
   logic            s_last = 1'b0;
   logic            w_en, r_en;
   logic [WDW-1:0]  w_data;
   logic [W_AW-1:0] w_addr_max;
   logic [R_AW-1:0] r_addr_max;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic            m_last, done, err_last;

   int n_checks = 0;
   int n_pass   = 0;
   bit sb_q[$];

   shift_reg_loader dut (
      .clk(clk), .resetn(resetn), .clken(clken),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_w_addr_max(cfg_w_addr_max), .cfg_r_addr_max(cfg_r_addr_max), .cfg_passes(cfg_passes),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .w_en(w_en), .r_en(r_en), .w_data(w_data),
      .w_addr_max(w_addr_max), .r_addr_max(r_addr_max),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .done(done), .err_last(err_last)
   );

   always #5 clk = ~clk;

   // One full tile: configure, load, stream; expected m_last per handshake is queued up front.
   task automatic run_tile(input int w_max, input int r_max, input int passes, input int sl_beat,
                           input bit bp, input int stall_at, input bit exp_err, input string tag);
      int beats = 0;
      int hs = 0;
      int last_hs = -10;
      int load_end = -10;
      int done_cyc = -1;
      int stall_left = 5;
      int mv_seen = 0;
      int bad_ren = 0;
      bit exp_last;
      sb_q.delete();
      for (int p = 0; p < passes; p++)
         for (int e = 0; e <= r_max; e++) sb_q.push_back(e == r_max);
      @(negedge clk);
      cfg_valid = 1'b1; clken = 1'b1;
      cfg_w_addr_max = W_AW'(w_max); cfg_r_addr_max = R_AW'(r_max); cfg_passes = PW'(passes);
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL %s cfg_ready got %b want 1", tag, cfg_ready);
      else n_pass++;
      for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         cfg_valid = 1'b0;
         clken = 1'b1;
         s_valid = (beats <= w_max);
         s_last = s_valid && (beats == sl_beat);
         s_data = {6{$urandom()}};
         m_ready = bp ? (cyc % 2 == 0) : 1'b1;
         if (stall_at > 0 && hs == stall_at && stall_left > 0) begin
            clken = 1'b0;
            stall_left--;
         end
         #1;
         if (cyc == 0) begin
            n_checks++;
            if ({s_ready, err_last, w_addr_max, r_addr_max} !== {2'b10, W_AW'(w_max), R_AW'(r_max)})
               $display("FAIL %s after_cfg s_ready/err/wmax/rmax got %b %b %0d %0d want 1 0 %0d %0d",
                        tag, s_ready, err_last, w_addr_max, r_addr_max, w_max, r_max);
            else n_pass++;
         end
         if (!clken) begin
            n_checks++;
            if ({m_valid, r_en, s_ready} !== 3'b000)
               $display("FAIL %s stall m_valid/r_en/s_ready got %b%b%b want 000", tag, m_valid, r_en, s_ready);
            else n_pass++;
         end
         if (passes > 0 && cyc == load_end + 1) begin
            n_checks++;
            if (m_valid !== 1'b1) $display("FAIL %s m_valid_after_load got %b want 1", tag, m_valid);
            else n_pass++;
         end
         if (m_valid) mv_seen++;
         if (w_en) begin
            n_checks++;
            if (w_data !== s_data) $display("FAIL %s w_data got %h want %h", tag, w_data, s_data);
            else n_pass++;
            beats++;
            last_hs = cyc;
            if (beats == w_max + 1) load_end = cyc;
         end
         if (r_en) begin
            if (!m_ready) bad_ren++;
            hs++;
            last_hs = cyc;
            n_checks++;
            if (sb_q.size() == 0) begin
               $display("FAIL %s extra_handshake %0d got m_last %b want none", tag, hs, m_last);
            end else begin
               exp_last = sb_q.pop_front();
               if (m_last !== exp_last)
                  $display("FAIL %s m_last hs %0d got %b want %b", tag, hs, m_last, exp_last);
               else n_pass++;
            end
         end
         if (done === 1'b1) begin
            done_cyc = cyc;
            n_checks++;
            if (cfg_ready !== 1'b1) $display("FAIL %s cfg_ready_at_done got %b want 1", tag, cfg_ready);
            else n_pass++;
         end
      end
      s_valid = 1'b0; s_last = 1'b0; clken = 1'b1;
      n_checks++;
      if (done_cyc < 0) $display("FAIL %s done_timeout got none want pulse", tag);
      else n_pass++;
      n_checks++;
      if (done_cyc != last_hs + 1) $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, last_hs + 1);
      else n_pass++;
      n_checks++;
      if (beats != w_max + 1) $display("FAIL %s w_en_count got %0d want %0d", tag, beats, w_max + 1);
      else n_pass++;
      n_checks++;
      if (hs != passes * (r_max + 1)) $display("FAIL %s r_en_count got %0d want %0d", tag, hs, passes * (r_max + 1));
      else n_pass++;
      n_checks++;
      if (sb_q.size() != 0) $display("FAIL %s scoreboard_left got %0d want 0", tag, sb_q.size());
      else n_pass++;
      n_checks++;
      if (bad_ren != 0) $display("FAIL %s r_en_without_m_ready got %0d want 0", tag, bad_ren);
      else n_pass++;
      n_checks++;
      if (err_last !== exp_err) $display("FAIL %s err_last got %b want %b", tag, err_last, exp_err);
      else n_pass++;
      if (passes == 0) begin
         n_checks++;
         if (mv_seen != 0) $display("FAIL %s m_valid_in_load_only got %0d want 0", tag, mv_seen);
         else n_pass++;
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) $display("FAIL %s done_width got %b want 0", tag, done);
      else n_pass++;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({cfg_ready, s_ready, w_en, r_en, m_valid, m_last, done, err_last, w_addr_max, r_addr_max} !== {8'b1000_0000, 6'd0})
         $display("FAIL reset outputs got %b%b%b%b%b%b%b%b %0d %0d want 10000000 0 0", cfg_ready, s_ready, w_en,
                  r_en, m_valid, m_last, done, err_last, w_addr_max, r_addr_max);
      else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_nominal();
      run_tile(1, 23, 2, 1, 1'b0, 0, 1'b0, "nominal");
   endtask

   task automatic test_backpressure();
      run_tile(1, 23, 2, 1, 1'b1, 0, 1'b0, "backpressure");
   endtask

   task automatic test_short_pass();
      run_tile(1, 11, 3, 1, 1'b0, 0, 1'b0, "short_pass");
   endtask

   task automatic test_load_only();
      run_tile(1, 23, 0, 1, 1'b0, 0, 1'b0, "load_only");
   endtask

   task automatic test_err_last();
      run_tile(1, 23, 2, 0, 1'b0, 0, 1'b1, "err_last");
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (err_last !== 1'b1) $display("FAIL err_sticky got %b want 1", err_last);
      else n_pass++;
   endtask

   task automatic test_stall_reset();
      run_tile(1, 23, 2, 1, 1'b0, 10, 1'b0, "stall");
      @(negedge clk);
      cfg_valid = 1'b1; cfg_w_addr_max = 1'b1; cfg_r_addr_max = 5'd23; cfg_passes = 16'd2;
      @(negedge clk);
      cfg_valid = 1'b0; s_valid = 1'b1; s_last = 1'b1;
      #1;
      n_checks++;
      if (w_en !== 1'b1) $display("FAIL reset_mid_load first_beat w_en got %b want 1", w_en);
      else n_pass++;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      resetn = 1'b0;
      #1;
      n_checks++;
      if ({cfg_ready, s_ready, w_en, r_en, m_valid, m_last, done, err_last, w_addr_max, r_addr_max} !== {8'b1000_0000, 6'd0})
         $display("FAIL reset_mid_load outputs got %b%b%b%b%b%b%b%b %0d %0d want 10000000 0 0", cfg_ready, s_ready,
                  w_en, r_en, m_valid, m_last, done, err_last, w_addr_max, r_addr_max);
      else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if ({cfg_ready, s_ready} !== 2'b10) $display("FAIL after_reset cfg_ready/s_ready got %b%b want 10", cfg_ready, s_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_short_pass();
      test_load_only();
      test_err_last();
      test_nominal();
      test_stall_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
